spi_host_ctrl: RTL and testbench

- SPI controller (initiator) that drives the accelerator's SPI register interface from the host side.
- Converts single-register write/read requests into framed SPI transactions:
  - SPI mode 0.
  - MSB first.
  - Frame = R/W bit, then address, then data.
- Returns read data and a completion pulse.
- Used in system-level test harnesses and in host FPGA glue to load P, E, M, Const, issue start/stop and read C.

---
 rtl/spi_host_pkg.sv | 21 ++
 rtl/spi_host_clkdiv.sv | 27 ++
 rtl/spi_host_ctrl.sv | 138 +++++++++++++
 tb/tb_spi_host_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_host_pkg.sv
// rtl/spi_host_pkg.sv - shared types and frame helpers for the SPI host controller
package spi_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      CS_GAP
   } state_t;

   function automatic int frame_w(input int addr_w, input int width);
      return 1 + addr_w + width;
   endfunction

   // The R/W flag is the first bit on the wire; 1 means write.
   function automatic int rw_bit_pos(input int addr_w, input int width);
      return frame_w(addr_w, width) - 1;
   endfunction

endpackage

// File: rtl/spi_host_clkdiv.sv
// rtl/spi_host_clkdiv.sv - SCLK half-period tick generator
module spi_host_clkdiv #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (ena) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = ena && (cnt == LAST);

endmodule

// File: rtl/spi_host_ctrl.sv
// rtl/spi_host_ctrl.sv - SPI mode-0 host turning register requests into framed transfers
// Optional SPI_HOST_LOOPBACK_EN adds a loopback input that samples MOSI instead of MISO.
module spi_host_ctrl
   import spi_host_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int ADDR_W  = 7,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              rsp_valid,
   output logic [WIDTH-1:0]  rsp_rdata,
   output logic              busy,
   output logic              spi_cs_n,
   output logic              spi_clk,
   output logic              spi_mosi,
`ifdef SPI_HOST_LOOPBACK_EN
   input  logic              loopback,
`endif
   input  logic              spi_miso
);

   localparam int FRAME_W = frame_w(ADDR_W, WIDTH);
   localparam int RW_POS  = rw_bit_pos(ADDR_W, WIDTH);
   localparam int BIT_W   = $clog2(FRAME_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

   state_t               state;
   state_t               state_nxt;
   logic [FRAME_W-1:0]   tx;
   logic [FRAME_W-1:0]   frame_ld;
   logic [WIDTH-1:0]     rx;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 sclk;
   logic                 tick;
   logic                 accept;
   logic                 miso_bit;
   logic                 cs_active;

   assign req_ready = (state == IDLE) && ena && !rst;
   assign accept    = req_valid && req_ready;

   spi_host_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .clr  (accept),
      .tick (tick)
   );

`ifdef SPI_HOST_LOOPBACK_EN
   logic lb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lb_q <= 1'b0;
      end else if (accept) begin
         lb_q <= loopback;
      end
   end

   assign miso_bit = lb_q ? tx[FRAME_W-1] : spi_miso;
`else
   assign miso_bit = spi_miso;
`endif

   always_comb begin
      frame_ld         = {1'b0, req_addr, req_wdata};
      frame_ld[RW_POS] = req_write;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = CS_SETUP;
         CS_SETUP: if (tick) state_nxt = SHIFT;
         SHIFT:    if (tick && sclk && (bit_cnt == LAST_BIT)) state_nxt = CS_HOLD;
         CS_HOLD:  if (tick) state_nxt = CS_GAP;
         CS_GAP:   if (tick) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cs_active = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);
      spi_cs_n  = !cs_active;
      spi_mosi  = cs_active ? tx[FRAME_W-1] : 1'b0;
      spi_clk   = sclk;
      busy      = (state != IDLE);
   end

   // Falling SCLK edge both samples MISO and advances MOSI; zeros shift in behind the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx        <= '0;
         rx        <= '0;
         bit_cnt   <= '0;
         sclk      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else if (ena) begin
         rsp_valid <= (state == CS_GAP) && tick;
         if (accept) begin
            tx      <= frame_ld;
            bit_cnt <= '0;
            sclk    <= 1'b0;
         end else if ((state == SHIFT) && tick) begin
            if (!sclk) begin
               sclk <= 1'b1;
            end else begin
               sclk    <= 1'b0;
               rx      <= {rx[WIDTH-2:0], miso_bit};
               tx      <= {tx[FRAME_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
         if ((state == CS_GAP) && tick) begin
            rsp_rdata <= rx;
         end
      end
   end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// tb/tb_spi_host_ctrl.sv - self-checking bench for spi_host_ctrl with SPI slave and timeline model
module tb_spi_host_ctrl;

   localparam int D      = 4;
   localparam int AW     = 7;
   localparam int W      = 8;
   localparam int F      = 1 + AW + W;
   localparam int LAT    = (3 + 2 * F) * D;
   localparam int CS_LOW = (2 + 2 * F) * D;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ena = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [W-1:0]  req_wdata = '0;
   logic          spi_miso = 1'b0;
   logic          req_ready, rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi;
   logic [W-1:0]  rsp_rdata;
`ifdef SPI_HOST_LOOPBACK_EN
   logic          loopback = 1'b0;
`endif

   always #5 clk = ~clk;

   spi_host_ctrl #(.WIDTH(W), .ADDR_W(AW), .CLK_DIV(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .spi_cs_n  (spi_cs_n),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
`ifdef SPI_HOST_LOOPBACK_EN
      .loopback  (loopback),
`endif
      .spi_miso  (spi_miso)
   );

   int tests = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: one transfer is a fixed LAT-cycle timeline
   int            cyc = 0;
   bit            m_busy = 1'b0;
   int            m_rem = 0;
   logic [F-1:0]  m_frame = '0;
   logic [AW-1:0] m_addr = '0;
   logic          m_write = 1'b0;
   logic [W-1:0]  m_wdata = '0;
   logic          m_lb = 1'b0;
   logic          m_exp_rsp = 1'b0;
   logic [W-1:0]  m_rdata_exp = '0;
   logic [W-1:0]  mem_m [128];
   int            acc_cyc = 0, rsp_cyc = 0, dut_rsp_cnt = 0;
   int            cs_lo_run = 0, cs_hi_run = 0, last_cs_low = 0, last_cs_high = 0;
   logic          s_rst, s_ena, s_valid, s_write, s_lb;
   logic [AW-1:0] s_addr;
   logic [W-1:0]  s_wdata;

   function automatic logic exp_cs_n(input bit b, input int rem);
      int e = LAT - rem;
      return !(b && (e < CS_LOW));
   endfunction

   function automatic logic exp_sclk(input bit b, input int rem);
      int e = LAT - rem;
      if (!b || e < D || e >= D + 2 * F * D) return 1'b0;
      return (((e - D) / D) % 2) == 1;
   endfunction

   function automatic logic exp_mosi(input bit b, input int rem, input logic [F-1:0] fr);
      int e = LAT - rem;
      if (!b) return 1'b0;
      if (e < D) return fr[F-1];
      if (e < D + 2 * F * D) return fr[F-1-((e - D) / (2 * D))];
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      s_rst   = rst;
      s_ena   = ena;
      s_valid = req_valid;
      s_write = req_write;
      s_addr  = req_addr;
      s_wdata = req_wdata;
`ifdef SPI_HOST_LOOPBACK_EN
      s_lb    = loopback;
`else
      s_lb    = 1'b0;
`endif
      cyc++;
      if (s_rst) begin
         m_busy      = 1'b0;
         m_rem       = 0;
         m_exp_rsp   = 1'b0;
         m_rdata_exp = '0;
      end else if (s_ena) begin
         m_exp_rsp = 1'b0;
         if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy      = 1'b0;
               m_exp_rsp   = 1'b1;
               m_rdata_exp = m_lb ? m_wdata : mem_m[m_addr];
               if (m_write) mem_m[m_addr] = m_wdata;
               rsp_cyc = cyc;
            end
         end else if (s_valid) begin
            m_busy  = 1'b1;
            m_rem   = LAT;
            m_frame = {s_write, s_addr, s_wdata};
            m_write = s_write;
            m_addr  = s_addr;
            m_wdata = s_wdata;
            m_lb    = s_lb;
            acc_cyc = cyc;
         end
      end
      #1;
      chk("rsp_valid", rsp_valid, m_exp_rsp);
      chk("busy", busy, m_busy);
      chk("rsp_rdata", rsp_rdata, m_rdata_exp);
      chk("req_ready", req_ready, !m_busy && ena && !rst);
      chk("spi_cs_n", spi_cs_n, exp_cs_n(m_busy, m_rem));
      chk("spi_clk", spi_clk, exp_sclk(m_busy, m_rem));
      chk("spi_mosi", spi_mosi, exp_mosi(m_busy, m_rem, m_frame));
      if (rsp_valid) dut_rsp_cnt++;
      if (spi_cs_n) begin
         cs_hi_run++;
         if (cs_lo_run > 0) begin last_cs_low = cs_lo_run; cs_lo_run = 0; end
      end else begin
         cs_lo_run++;
         if (cs_hi_run > 0) begin last_cs_high = cs_hi_run; cs_hi_run = 0; end
      end
   end

   // ---------------- SPI slave: register file, drives MISO in the data phase
   int           sl_cnt = 0;
   logic         sl_prev = 1'b0;
   logic [F-1:0] sl_cap = '0;
   logic [W-1:0] sl_rd = '0;
   logic [W-1:0] sl_mem [128];
   logic [F-1:0] sl_last = '0;
   int           sl_last_edges = 0;
   bit           sl_quiet = 1'b0;

   always @(negedge clk) begin
      if (spi_cs_n) begin
         if (sl_cnt > 0) begin sl_last = sl_cap; sl_last_edges = sl_cnt; end
         sl_cnt   = 0;
         spi_miso = 1'b0;
      end else if (spi_clk && !sl_prev) begin
         sl_cnt++;
         sl_cap = {sl_cap[F-2:0], spi_mosi};
         if (sl_cnt == 1 + AW) sl_rd = sl_mem[sl_cap[AW-1:0]];
         if (sl_cnt > 1 + AW && sl_cnt <= F) spi_miso = sl_quiet ? 1'b0 : sl_rd[F-sl_cnt];
         if (sl_cnt == F && sl_cap[F-1]) sl_mem[sl_cap[F-2:W]] = sl_cap[W-1:0];
      end
      sl_prev = spi_clk;
   end

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem_m[i]  = W'((i * 37 + 11) & 8'hFF);
         sl_mem[i] = W'((i * 37 + 11) & 8'hFF);
      end
      mem_m[5]  = 8'h3C;
      sl_mem[5] = 8'h3C;
   end

   // ---------------- drivers
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
      bit ok = 1'b0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 400; i++) begin
         if (req_ready) begin ok = 1'b1; @(posedge clk); break; end
         @(negedge clk);
      end
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      req_wdata = W'($urandom);
      chk("accept_timeout", ok, 1'b1);
   endtask

   task automatic wait_rsp(input bit allow_stall);
      bit got = 1'b0;
      int stall = 0;
      for (int i = 0; i < 4 * LAT; i++) begin
         @(negedge clk);
         if (rsp_valid) begin got = 1'b1; break; end
         if (stall > 0) begin
            stall--;
            if (stall == 0) ena = 1'b1;
         end else if (allow_stall && busy && $urandom_range(0, 40) == 0) begin
            ena   = 1'b0;
            stall = $urandom_range(1, 6);
         end
      end
      ena = 1'b1;
      chk("rsp_timeout", got, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_cs_n", spi_cs_n, 1'b1);
      chk("rst_sclk", spi_clk, 1'b0);
      chk("rst_mosi", spi_mosi, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", req_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      send(1'b1, 7'h01, 8'hA5);
      wait_rsp(1'b0);
      chk("wr_latency", rsp_cyc - acc_cyc, 140);
      chk("wr_mosi_frame", sl_last, 16'h81A5);
      chk("wr_sclk_rises", sl_last_edges, 16);
      chk("wr_cs_low_cycles", last_cs_low, 136);
      repeat (3) @(negedge clk);

      send(1'b0, 7'h05, 8'hEE);
      wait_rsp(1'b0);
      chk("rd_rdata", rsp_rdata, 8'h3C);
      chk("rd_mosi_header", sl_last[15:8], 8'h05);
      chk("rd_sclk_rises", sl_last_edges, 16);
      repeat (3) @(negedge clk);

      send(1'b1, 7'h02, 8'h11);
      wait_rsp(1'b0);
      send(1'b0, 7'h02, 8'h00);
      wait_rsp(1'b0);
      chk("b2b_rdata", rsp_rdata, 8'h11);
      chk("b2b_cs_high_cycles", last_cs_high, D + 1);
      repeat (3) @(negedge clk);

      send(1'b1, 7'h10, 8'h5A);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (sl_cnt == 7) break;
      end
      chk("rst_mid_reached", sl_cnt, 7);
      n0 = dut_rsp_cnt;
      rst = 1'b1;
      @(posedge clk);
      #2;
      chk("rst_mid_cs_n", spi_cs_n, 1'b1);
      chk("rst_mid_sclk", spi_clk, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("rst_mid_no_rsp", dut_rsp_cnt, n0);
      send(1'b1, 7'h10, 8'h5A);
      wait_rsp(1'b0);
      send(1'b0, 7'h10, 8'h00);
      wait_rsp(1'b0);
      chk("rst_mid_readback", rsp_rdata, 8'h5A);
      repeat (3) @(negedge clk);

      send(1'b0, 7'h05, 8'h00);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (sl_cnt == 3) break;
      end
      ena = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("ena_sclk_held", spi_clk, 1'b1);
      chk("ena_cs_held", spi_cs_n, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      ena = 1'b1;
      wait_rsp(1'b0);
      chk("ena_latency", rsp_cyc - acc_cyc, 150);
      chk("ena_rdata", rsp_rdata, 8'h3C);

`ifdef SPI_HOST_LOOPBACK_EN
      repeat (3) @(negedge clk);
      sl_quiet = 1'b1;
      loopback = 1'b1;
      send(1'b1, 7'h7F, 8'hC3);
      loopback = 1'b0;
      wait_rsp(1'b0);
      chk("loopback_rdata", rsp_rdata, 8'hC3);
      sl_quiet = 1'b0;
`endif

      for (int t = 0; t < 40; t++) begin
         int gap = $urandom_range(0, 3);
         send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), W'($urandom));
         wait_rsp(1'b1);
         repeat (gap) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
